// File: rtl/mt_pkg.sv
// Shared types and constants for the MT random-number arbiter slice.
package mt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int          DEF_NUM_REQ    = 4;
  localparam int          DEF_FIFO_DEPTH = 8;
  localparam logic [31:0] MATRIX_A       = 32'h9908B0DF;

endpackage

// File: rtl/mt_rn_fifo.sv
// Power-of-two word FIFO: registered pointers/count, combinational head, synchronous flush.
module mt_rn_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   wr_en_i,
  input  logic [W-1:0]           wr_data_i,
  input  logic                   rd_en_i,
  output logic [W-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_en_i && !rd_en_i)      count_d = count_q + 1'b1;
      else if (!wr_en_i && rd_en_i) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = count_q;
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/mt_rn_arbiter.sv
// Seeds an MT generator, buffers its words and hands them round-robin to requesters.
// Optional MT_RN_ARB_DROP_CNT_EN adds a saturating dropped-word counter.
module mt_rn_arbiter
  import mt_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        seed_start,
  output logic                        gen_seed_enable,
  input  logic [31:0]                 rn_in,
  input  logic                        rn_in_valid,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [31:0]                 rn_out,
  output logic                        rn_out_valid,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic [15:0]                 drop_count
);
  localparam int IW = $clog2(NUM_REQ);

  state_e state_q, state_d;

  logic               run, rd_en, wr_en, drop;
  logic               fifo_full, fifo_empty;
  logic [31:0]        head;
  logic [IW-1:0]      ptr_q, ptr_d, pick;
  logic               pick_vld;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [31:0]        rn_out_q;
  logic               vld_q, overflow_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (seed_start) state_d = SEED;
      SEED:    state_d = RUN;
      RUN:     if (seed_start) state_d = SEED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign gen_seed_enable = (state_q == SEED);
  assign run             = (state_q == RUN);

  // A reseed in RUN flushes the buffer, so it also blocks reads and writes that cycle.
  assign rd_en = run && !seed_start && !fifo_empty && (|req);
  assign wr_en = run && !seed_start && rn_in_valid && (!fifo_full || rd_en);
  assign drop  = run && !seed_start && rn_in_valid && fifo_full && !rd_en;

  mt_rn_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (run && seed_start),
    .wr_en_i   (wr_en),
    .wr_data_i (rn_in),
    .rd_en_i   (rd_en),
    .rd_data_o (head),
    .level_o   (level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Scan downward so the requester closest after ptr_q is the last (winning) hit.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (req[idx]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_d = '0;
    ptr_d = ptr_q;
    if (rd_en && pick_vld) begin
      gnt_d = NUM_REQ'(1) << pick;
      ptr_d = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q      <= '0;
      rn_out_q   <= '0;
      vld_q      <= 1'b0;
      ptr_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      gnt_q <= gnt_d;
      vld_q <= rd_en;
      ptr_q <= ptr_d;
      if (rd_en) rn_out_q <= head;
      if (seed_start) overflow_q <= 1'b0;
      else if (drop)  overflow_q <= 1'b1;
    end
  end

  assign gnt          = gnt_q;
  assign rn_out       = rn_out_q;
  assign rn_out_valid = vld_q;
  assign overflow     = overflow_q;

`ifdef MT_RN_ARB_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                drop_cnt_q <= '0;
    else if (seed_start)                     drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: doc/mt_rn_arbiter.md
MT_RN_ARBITER -- requirements
Module: mt_rn_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, buffered random words (power of 2, 2..64).
REQ-003 SHALL have ports clk input 1, rising-edge clock; rst input 1, reset, asynchronous and active-low.
REQ-004 SHALL have port seed_start input 1, one-cycle request to (re)seed generator.
REQ-005 SHALL have port gen_seed_enable output 1, one-cycle pulse to generator seed-enable input.
REQ-006 SHALL have ports rn_in input 32 and rn_in_valid input 1, generator word and qualifier; no backpressure.
REQ-007 SHALL have port req input NUM_REQ, level request per requester.
REQ-008 SHALL have port gnt output NUM_REQ, one-hot grant, one cycle per delivered word.
REQ-009 SHALL have ports rn_out output 32 and rn_out_valid output 1, delivered word, valid coincident with gnt.
REQ-010 SHALL have ports level output $clog2(FIFO_DEPTH)+1, buffered word count; overflow output 1, sticky drop flag.
REQ-011 SHALL have port drop_count output 16, saturating count of dropped words.

Function
REQ-012 SHALL implement FSM states IDLE, SEED, RUN.
REQ-013 IDLE -> SEED on seed_start; SEED lasts exactly one cycle with gen_seed_enable=1; SEED -> RUN.
REQ-014 seed_start in RUN SHALL flush FIFO (level=0 next cycle), clear overflow, and pass through SEED again.
REQ-015 In IDLE and SEED, rn_in_valid SHALL be ignored and no grants issued.
REQ-016 In RUN, rn_in_valid=1 with FIFO not full SHALL write rn_in; level updates next cycle.
REQ-017 rn_in_valid=1 with FIFO full and no read that cycle SHALL drop the word and set overflow.
REQ-018 Simultaneous read and write when full SHALL accept the write (level unchanged).
REQ-019 Write to empty FIFO SHALL NOT be readable in the same cycle (no bypass); earliest delivery one cycle later.
REQ-020 Arbitration: when RUN, level>0 and |req, exactly one requester SHALL be granted, chosen round-robin starting after the last granted index (index 0 first after reset).
REQ-021 gnt, rn_out, rn_out_valid SHALL be registered: request seen at cycle N -> gnt/rn_out_valid high at N+1 with FIFO head word.
REQ-022 One grant per cycle maximum; continuous req with level>0 SHALL yield back-to-back grants at one word per cycle.
REQ-023 Requester dropping req in cycle N SHALL not be granted at N+1.
REQ-024 When not granting, gnt=0, rn_out_valid=0, rn_out holds last value.
REQ-025 Pointer and level arithmetic SHALL wrap modulo FIFO_DEPTH; level never exceeds FIFO_DEPTH.

Reset
REQ-026 rst low SHALL asynchronously force: state IDLE, gen_seed_enable=0, gnt=0, rn_out=0, rn_out_valid=0, level=0, overflow=0, drop_count=0, round-robin pointer to index 0.
REQ-027 rst asserted mid-operation SHALL discard buffered words; release returns to IDLE awaiting seed_start.

Configuration
REQ-028 Macro MT_RN_ARB_DROP_CNT_EN defined: drop_count increments per dropped word, saturates at 16'hFFFF, clears with overflow on seed_start.
REQ-029 Macro undefined: drop_count port present, tied to 0, no counter logic; overflow behaviour unchanged.

Structure
REQ-030 Shared package mt_pkg SHALL hold FSM state typedef, default NUM_REQ/FIFO_DEPTH constants and generator MATRIX_A constant 32'h9908B0DF.
REQ-031 FIFO storage and pointers SHALL be sub-module mt_rn_fifo; arbitration and FSM reside in mt_rn_arbiter.

Verification
REQ-032 Reset, seed_start pulse -> gen_seed_enable high exactly one cycle later for one cycle, state RUN after.
REQ-033 Push 3 words (0x11,0x22,0x33), req=4'b1111 held -> gnt 0001,0010,0100 on consecutive cycles with rn_out 0x11,0x22,0x33, then gnt=0.
REQ-034 Push 10 words, no req, FIFO_DEPTH=8 -> level=8, overflow=1, drop_count=2 (macro on) / 0 (macro off).
REQ-035 Full FIFO, req=4'b0001 and rn_in_valid same cycle -> word accepted, level stays 8, overflow unchanged.
REQ-036 Buffered words, rst pulled low mid-grant -> all outputs zero immediately; after release no grant until seed_start and new writes.
REQ-037 seed_start in RUN with level=5 -> level=0, overflow=0, one gen_seed_enable pulse.
